tick_gen: RTL

Upstream stage of the seconds counter; produces its single-cycle `tick` strobe.
- Run mode (display=0): a free-running prescaler divides clk down to one tick per DIV cycles.
- Setup mode (display=1): the user's inc/dec push-button is synchronized and debounced. It yields one tick per press, plus auto-repeat while the button is held.
- `tick` fans out to the seconds/minutes/hours counters; `btn_db` is available to the setup-control logic.

---
 rtl/tick_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tick_gen.sv
// Tick source for the seconds counter: run-mode prescaler plus setup-mode debounced
// push-button with auto-repeat. Define TICK_GEN_ACCEL_EN to shorten the repeat period after 8 repeats.
module tick_gen #(
    parameter int DIV        = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic display,
    input  logic btn,
    output logic tick,
    output logic btn_db
);

    localparam int PW   = $clog2(DIV);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW   = $clog2(TMAX);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_t;

    logic            s1_p0;
    logic            s2_p1;
    logic            db_prev;
    logic [DW-1:0]   deb_cnt;
    logic            display_q;
    logic [PW-1:0]   presc, presc_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [TW-1:0]   rep_last;
    rep_state_t      state, state_nxt;
    logic            tick_nxt;
    logic            mode_chg;
    logic            db_rise;

    assign mode_chg = (display != display_q);
    assign db_rise  = btn_db & ~db_prev;

`ifdef TICK_GEN_ACCEL_EN
    localparam logic [TW-1:0] FAST_LAST = TW'((REP_PERIOD >> 2) - 1);

    logic [3:0] accel_cnt, accel_nxt;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign rep_last = (accel_cnt >= 4'd8) ? FAST_LAST : PERIOD_LAST;
`else
    assign rep_last = PERIOD_LAST;
`endif

    // Stage p0/p1: two-flop synchronizer, then debounce on the p1 level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p0   <= 1'b0;
            s2_p1   <= 1'b0;
            btn_db  <= 1'b0;
            db_prev <= 1'b0;
            deb_cnt <= '0;
        end else begin
            s1_p0   <= btn;
            s2_p1   <= s1_p0;
            db_prev <= btn_db;
            if (s2_p1 != btn_db) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_db  <= s2_p1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Tick generation: prescaler in run mode, repeat FSM in setup mode
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        presc_nxt = presc;
        tick_nxt  = 1'b0;
        if (mode_chg) begin
            // A mode change resets both tick sources and never ticks itself
            state_nxt = R_IDLE;
            timer_nxt = '0;
            presc_nxt = '0;
        end else if (!display) begin
            state_nxt = R_IDLE;
            timer_nxt = '0;
            if (presc == PRESC_LAST) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end else begin
            presc_nxt = '0;
            case (state)
                R_IDLE: begin
                    if (db_rise) begin
                        tick_nxt  = 1'b1;
                        timer_nxt = '0;
                        state_nxt = R_DELAY;
                    end
                end
                R_DELAY: begin
                    if (!btn_db) begin
                        state_nxt = R_IDLE;
                        timer_nxt = '0;
                    end else if (timer == DELAY_LAST) begin
                        tick_nxt  = 1'b1;
                        timer_nxt = '0;
                        state_nxt = R_REPEAT;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                R_REPEAT: begin
                    if (!btn_db) begin
                        state_nxt = R_IDLE;
                        timer_nxt = '0;
                    end else if (timer == rep_last) begin
                        tick_nxt  = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = R_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

`ifdef TICK_GEN_ACCEL_EN
    always_comb begin
        accel_nxt = accel_cnt;
        if (mode_chg || state_nxt != R_REPEAT)
            accel_nxt = 4'd0;
        else if (state == R_REPEAT && tick_nxt)
            accel_nxt = sat_inc4(accel_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst)
            accel_cnt <= 4'd0;
        else
            accel_cnt <= accel_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            timer     <= '0;
            presc     <= '0;
            display_q <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            presc     <= presc_nxt;
            display_q <= display;
            tick      <= tick_nxt;
        end
    end

endmodule
